// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one multi-cycle ALU
// Ready is combinational from valid in IDLE; responses, result and grant are registered.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [2:0]  req0_ALUop,
    input  logic [4:0]  req0_S,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [2:0]  req1_ALUop,
    input  logic [4:0]  req1_S,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_C,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_code;
    logic [4:0]  op_s;

    logic        win;
    logic        accept;
    logic        consume;
    logic [31:0] alu_res;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = req1_valid;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = reset && (state == IDLE) && req0_valid && !win;
    assign req1_ready = reset && (state == IDLE) && req1_valid && win;
    assign consume    = grant_id ? resp1_ready : resp0_ready;

    always_comb begin
        alu_res = 32'd0;
        case (op_code)
            3'b000: alu_res = op_a + op_b;
            3'b001: alu_res = op_a - op_b;
            3'b010: alu_res = op_a | op_b;
            3'b011: alu_res = {31'd0, op_a == op_b};
            3'b100: alu_res = op_a & op_b;
            3'b101: alu_res = {31'd0, !op_a[31] && (op_a != 32'd0) && ((op_a & (op_a - 32'd1)) == 32'd0)};
            3'b110: alu_res = 32'($signed(op_b) >>> op_s);
            default: alu_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= 1'b1;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            op_code     <= 3'd0;
            op_s        <= 5'd0;
            resp_C      <= 32'd0;
            grant_id    <= 1'b0;
            busy        <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= win ? req1_A : req0_A;
                        op_b       <= win ? req1_B : req0_B;
                        op_code    <= win ? req1_ALUop : req0_ALUop;
                        op_s       <= win ? req1_S : req0_S;
                        grant_id   <= win;
                        last_grant <= win;
                        cnt        <= 4'(EXEC_CYCLES - 1);
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        resp_C      <= alu_res;
                        resp0_valid <= !grant_id;
                        resp1_valid <= grant_id;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (consume) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and random checks of alu_arbiter against a reference model
// Two instances (EXEC_CYCLES 1 and 4) share inputs; the idle one is held in reset.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst4, sel;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic [4:0]  s0, s1;

    logic        x_rdy0, x_rdy1, x_rv0, x_rv1, x_busy, x_gid;
    logic        y_rdy0, y_rdy1, y_rv0, y_rv1, y_busy, y_gid;
    logic [31:0] x_c, y_c;

    wire        rdy0  = sel ? y_rdy0 : x_rdy0;
    wire        rdy1  = sel ? y_rdy1 : x_rdy1;
    wire        rv0   = sel ? y_rv0  : x_rv0;
    wire        rv1   = sel ? y_rv1  : x_rv1;
    wire        busy  = sel ? y_busy : x_busy;
    wire        gid   = sel ? y_gid  : x_gid;
    wire [31:0] rc    = sel ? y_c    : x_c;

    alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst1),
        .req0_valid(v0), .req0_ready(x_rdy0), .req0_A(a0), .req0_B(b0), .req0_ALUop(op0), .req0_S(s0),
        .req1_valid(v1), .req1_ready(x_rdy1), .req1_A(a1), .req1_B(b1), .req1_ALUop(op1), .req1_S(s1),
        .resp0_valid(x_rv0), .resp0_ready(rr0), .resp1_valid(x_rv1), .resp1_ready(rr1),
        .resp_C(x_c), .busy(x_busy), .grant_id(x_gid)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .reset(rst4),
        .req0_valid(v0), .req0_ready(y_rdy0), .req0_A(a0), .req0_B(b0), .req0_ALUop(op0), .req0_S(s0),
        .req1_valid(v1), .req1_ready(y_rdy1), .req1_A(a1), .req1_B(b1), .req1_ALUop(op1), .req1_S(s1),
        .resp0_valid(y_rv0), .resp0_ready(rr0), .resp1_valid(y_rv1), .resp1_ready(rr1),
        .resp_C(y_c), .busy(y_busy), .grant_id(y_gid)
    );

    int nvec = 0;
    int nerr = 0;
    bit last;
    int ec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] s);
        logic [31:0] r;
        int ones;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a | b;
            3'd3: r = (a == b) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: begin
                ones = 0;
                for (int i = 0; i < 31; i++) ones += int'(a[i]);
                r = (!a[31] && ones == 1) ? 32'd1 : 32'd0;
            end
            3'd6: begin
                r = b;
                for (int i = 0; i < int'(s); i++) r = {r[31], r[31:1]};
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic issue(input bit iv0, input bit iv1,
                         input logic [31:0] ia0, input logic [31:0] ib0, input logic [2:0] iop0, input logic [4:0] is0,
                         input logic [31:0] ia1, input logic [31:0] ib1, input logic [2:0] iop1, input logic [4:0] is1,
                         input int hold);
        bit w;
        logic [31:0] exp;
        @(posedge clk);
        #1;
        v0 = iv0; v1 = iv1; a0 = ia0; b0 = ib0; op0 = iop0; s0 = is0;
        a1 = ia1; b1 = ib1; op1 = iop1; s1 = is1; rr0 = 1'b0; rr1 = 1'b0;
        w   = (iv0 && iv1) ? !last : iv1;
        exp = w ? ref_alu(iop1, ia1, ib1, is1) : ref_alu(iop0, ia0, ib0, is0);
        @(negedge clk);
        chk("req0_ready_idle", 32'(rdy0), 32'(iv0 && !w));
        chk("req1_ready_idle", 32'(rdy1), 32'(iv1 && w));
        @(posedge clk);
        last = w;
        #1;
        a0 = $urandom; b0 = $urandom; op0 = 3'($urandom); s0 = 5'($urandom);
        a1 = $urandom; b1 = $urandom; op1 = 3'($urandom); s1 = 5'($urandom);
        for (int i = 0; i < ec; i++) begin
            @(negedge clk);
            chk("exec_busy", 32'(busy), 32'd1);
            chk("exec_resp_valid", {30'd0, rv1, rv0}, 32'd0);
            chk("exec_req_ready", {30'd0, rdy1, rdy0}, 32'd0);
            @(posedge clk);
        end
        for (int j = 0; j <= hold; j++) begin
            @(negedge clk);
            chk("resp_valid", {30'd0, rv1, rv0}, w ? 32'd2 : 32'd1);
            chk("resp_C", rc, exp);
            chk("grant_id", 32'(gid), 32'(w));
            chk("resp_req_ready", {30'd0, rdy1, rdy0}, 32'd0);
            if (j < hold) begin
                @(posedge clk);
                #1;
                if (w) rr0 = 1'b1; else rr1 = 1'b1;
            end
        end
        if (w) rr1 = 1'b1; else rr0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_resp_valid", {30'd0, rv1, rv0}, 32'd0);
        chk("idle_resp_C_hold", rc, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rv0b, rv1b;
        sel = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
        v0 = 1'b1; v1 = 1'b1; rr0 = 1'b0; rr1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        op0 = 3'd0; op1 = 3'd0; s0 = 5'd0; s1 = 5'd0;
        last = 1'b1; ec = 1;
        #12;
        chk("rst_ready", {30'd0, rdy1, rdy0}, 32'd0);
        chk("rst_resp_valid", {30'd0, rv1, rv0}, 32'd0);
        chk("rst_resp_C", rc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(gid), 32'd0);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        rst1 = 1'b1;

        issue(1, 0, 32'd5, 32'd3, 3'd0, 5'd0, 32'd0, 32'd0, 3'd0, 5'd0, 0);
        chk("single_op_sum", rc, 32'd8);
        last = 1'b1;

        // Reset again so the first tie is resolved from the reset value of last-grant.
        @(negedge clk); rst1 = 1'b0; #2; rst1 = 1'b1;
        for (int k = 0; k < 3; k++)
            issue(1, 1, $urandom, $urandom, 3'd0, 5'd0, $urandom, $urandom, 3'd2, 5'd0, 0);

        issue(1, 0, 32'd0, 32'd1, 3'd1, 5'd0, 0, 0, 3'd0, 5'd0, 0);
        chk("sub_wrap", rc, 32'hFFFF_FFFF);
        issue(1, 0, 32'h40, 32'd0, 3'd5, 5'd0, 0, 0, 3'd0, 5'd0, 0);
        chk("onehot_40", rc, 32'd1);
        issue(0, 1, 0, 0, 3'd0, 5'd0, 32'h8000_0001, 32'd0, 3'd5, 5'd0, 0);
        chk("onehot_msb", rc, 32'd0);
        issue(1, 0, 32'd3, 32'd0, 3'd5, 5'd0, 0, 0, 3'd0, 5'd0, 0);
        chk("onehot_3", rc, 32'd0);
        issue(0, 1, 0, 0, 3'd0, 5'd0, 32'd0, 32'h8000_0000, 3'd6, 5'd4, 0);
        chk("asr_4", rc, 32'hF800_0000);
        issue(1, 0, 32'hFFFF_FFFF, 32'h1234_5678, 3'd7, 5'd3, 0, 0, 3'd0, 5'd0, 0);
        chk("op7_zero", rc, 32'd0);

        issue(1, 0, 32'h1111_0000, 32'h0000_2222, 3'd2, 5'd0, 0, 0, 3'd0, 5'd0, 5);

        @(posedge clk); #1;
        v0 = 1'b1;
        #1;
        chk("drop_rdy0", {30'd0, rdy1, rdy0}, 32'd1);
        v0 = 1'b0; v1 = 1'b1;
        #1;
        chk("switch_rdy1", {30'd0, rdy1, rdy0}, 32'd2);
        v1 = 1'b0;
        @(negedge clk);
        chk("no_accept_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rv0b = 1'($urandom);
            rv1b = 1'($urandom);
            if (!rv0b && !rv1b) rv0b = 1'b1;
            ra = $urandom; rb = $urandom;
            if ((k % 5) == 0) rb = ra;
            if ((k % 7) == 0) ra = 32'd1 << $urandom_range(0, 31);
            issue(rv0b, rv1b, ra, rb, 3'($urandom), 5'($urandom),
                  rb, ra, 3'($urandom), 5'($urandom), $urandom_range(0, 3));
        end

        @(negedge clk);
        rst1 = 1'b0; sel = 1'b1; ec = 4; last = 1'b1;
        rst4 = 1'b1;
        issue(1, 0, 32'd100, 32'd23, 3'd0, 5'd0, 0, 0, 3'd0, 5'd0, 1);
        chk("exec4_sum", rc, 32'd123);

        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b1; a1 = 32'd7; b1 = 32'd9; op1 = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst4 = 1'b0;
        #1;
        chk("midexec_busy", 32'(busy), 32'd0);
        chk("midexec_resp_valid", {30'd0, rv1, rv0}, 32'd0);
        chk("midexec_resp_C", rc, 32'd0);
        chk("midexec_grant", 32'(gid), 32'd0);
        chk("midexec_ready", {30'd0, rdy1, rdy0}, 32'd0);
        v1 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1; last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_no_resp", {29'd0, busy, rv1, rv0}, 32'd0);
        end
        issue(1, 1, 32'd2, 32'd2, 3'd3, 5'd0, 32'd1, 32'd2, 3'd3, 5'd0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: EXEC_CYCLES, default 1, number of cycles in EXEC (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_A, req0_B / req1_A, req1_B  input  32  operands.
REQ-007 req0_ALUop / req1_ALUop  input  3  operation code.
REQ-008 req0_S / req1_S  input  5  shift amount.
REQ-009 resp0_valid / resp1_valid  output  1  result for requester n is held on resp_C.
REQ-010 resp0_ready / resp1_ready  input  1  requester n consumes the result.
REQ-011 resp_C  output  32  registered result, shared by both requesters.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 grant_id  output  1  requester owning the current or last operation.

Function
REQ-014 Opcodes: 000 A+B (mod 2^32); 001 A-B (mod 2^32); 010 A|B; 011 1 if A==B else 0; 100 A&B; 101 1 if A[31]==0 and exactly one of A[30:0] set, else 0; 110 B arithmetic-shifted right by S (vacated bits = B[31], S=0 returns B); 111 0.
REQ-015 FSM states: IDLE, EXEC, RESP; encoding free.
REQ-016 IDLE: reqn_ready = 1 only for the granted requester, and only when it has reqn_valid=1; both ready never high together.
REQ-017 Arbitration in IDLE: if one valid, grant it; if both valid, grant the one not granted last (round-robin); last-grant register resets to 1, so requester 0 wins the first tie.
REQ-018 Handshake reqn_valid & reqn_ready at edge N: latch A, B, ALUop, S, grant_id; go to EXEC; load cycle counter with EXEC_CYCLES-1.
REQ-019 EXEC: counter decrements each cycle; when counter is 0 at an edge, resp_C <= ALU result of latched operands, go to RESP.
REQ-020 With EXEC_CYCLES=1, respn_valid rises in cycle N+2 (two edges after acceptance).
REQ-021 RESP: resp{grant_id}_valid = 1, other resp_valid = 0; resp_C and grant_id hold stable until consumed.
REQ-022 RESP with respn_ready=1 for the owner at an edge: go to IDLE; respn_ready of the non-owner ignored.
REQ-023 No new acceptance in EXEC or RESP; all req_ready = 0 there; minimum issue interval is EXEC_CYCLES+2 cycles.
REQ-024 Operand/opcode changes on req ports after acceptance have no effect on the in-flight result.
REQ-025 A requester dropping valid before ready is legal; arbitration re-evaluates the same cycle.
REQ-026 resp_C holds its last value after returning to IDLE.

Reset
REQ-027 reset=0 forces immediately, regardless of state: state IDLE, counter 0, resp_C 0, grant_id 0, last-grant 1, all ready/valid outputs 0, busy 0.
REQ-028 Reset mid-EXEC or mid-RESP discards the operation; no respn_valid after release.
REQ-029 First acceptance possible on the first rising edge after reset returns to 1.

Verification
REQ-030 Single op: req0 A=5, B=3, op 000 -> req0_ready same cycle; resp0_valid at N+2, resp_C=8, grant_id=0.
REQ-031 Tie: both valid after reset -> req0 granted first, then req1, then req0 again while both stay valid; resp1_valid never high during req0 ops.
REQ-032 Ops sweep: op 001 A=0,B=1 -> FFFFFFFF; op 101 A=00000040 -> 1, A=80000001 -> 0, A=00000003 -> 0; op 110 B=80000000,S=4 -> F8000000; op 111 -> 0.
REQ-033 Backpressure: hold resp0_ready=0 for 5 cycles -> resp0_valid and resp_C stable, req ports not ready; ready=1 -> IDLE next cycle.
REQ-034 EXEC_CYCLES=4: resp valid at N+5; reset asserted mid-EXEC -> outputs zero immediately, no response after release.
